// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor sides).
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell; the only arithmetic logic in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, with start/done handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; last result held on sum/cout/ovf
//   ST_RUN  | one operand bit pair consumed per cycle, start ignored
//   ST_DONE | result valid, done high for this single cycle
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c_msb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_s;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_nxt;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    assign w_sum_nxt = {w_fa_s, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_c_msb  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_carry  <= cin;
        end else if (r_state == ST_RUN) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_sum_sh <= w_sum_nxt;
            r_carry  <= w_fa_cout;
            r_cnt    <= r_cnt + 1'b1;
            // Carry leaving bit WIDTH-2 is the carry into the sign bit.
            if (r_cnt == CNT_PRE) begin
                r_c_msb <= w_fa_cout;
            end
            if (w_last) begin
                r_sum  <= w_sum_nxt;
                r_cout <= w_fa_cout;
                r_ovf  <= r_c_msb ^ w_fa_cout;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder against a plain-arithmetic reference.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer addition, signed overflow from signed-range test.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mc,
                         output logic [7:0] es, output logic ec, output logic eo);
        int u;
        int s;
        u  = int'(ma) + int'(mb) + int'(mc);
        s  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        es = u[7:0];
        ec = (u > 255);
        eo = (s > 127) || (s < -128);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (done) break;
        end
        if (!done) chk({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input string tag);
        int         cyc;
        logic [7:0] es;
        logic       ec;
        logic       eo;
        model(ta, tb_v, tc, es, ec, eo);
        start = 1'b1; a = ta; b = tb_v; cin = tc;
        step();
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        wait_done(tag, cyc);
        chk({tag, " latency"}, 32'(cyc), 32'(WIDTH));
        chk({tag, " sum"}, 32'(sum), 32'(es));
        chk({tag, " cout"}, 32'(cout), 32'(ec));
        chk({tag, " ovf"}, 32'(ovf), 32'(eo));
        step();
        chk({tag, " done_once"}, 32'(done), 32'd0);
        chk({tag, " hold"}, {23'd0, ovf, cout, sum}, {23'd0, eo, ec, es});
    endtask

    initial begin
        int         cyc;
        int         n_done;
        logic [7:0] cap_sum;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        step(); step();
        chk("reset", {27'd0, busy, done, ovf, cout, 1'b0} | 32'(sum), 32'd0);
        rst_n = 1'b1;
        step();

        run_op(8'h35, 8'h4A, 1'b0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, "wrap");
        run_op(8'h00, 8'h00, 1'b1, "cin_only");
        run_op(8'h7F, 8'h01, 1'b0, "ovf_pos");
        run_op(8'h80, 8'h80, 1'b0, "ovf_neg");

        // start pulsed on RUN cycle 3 must be ignored
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        step();
        start = 1'b0;
        step(); step();
        start = 1'b1; a = 8'hAA; b = 8'h55;
        step();
        start = 1'b0;
        n_done = 0; cap_sum = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin n_done++; cap_sum = sum; end
            step();
        end
        chk("busy_ignore done_count", 32'(n_done), 32'd1);
        chk("busy_ignore sum", 32'(cap_sum), 32'h30);

        // back-to-back: start held through DONE
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        step();
        start = 1'b0;
        wait_done("b2b_first", cyc);
        chk("b2b first sum", 32'(sum), 32'h46);
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        step();
        start = 1'b0;
        chk("b2b accept busy", 32'(busy), 32'd1);
        chk("b2b accept done", 32'(done), 32'd0);
        wait_done("b2b_second", cyc);
        chk("b2b latency", 32'(cyc), 32'(WIDTH));
        chk("b2b sum", 32'(sum), 32'h03);
        step();

        // make outputs nonzero, then reset on RUN cycle 4
        run_op(8'h80, 8'h80, 1'b1, "pre_reset");
        start = 1'b1; a = 8'hC3; b = 8'h5A; cin = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst_n = 1'b0; start = 1'b1;
        step();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            if (done || busy) n_done++;
            step();
        end
        chk("rst no activity", 32'(n_done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
